// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan controller and its helpers.
// Combinational only; no latency and no flow control.
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mux4.sv
// Downstream 4:1 bit mux driven by the scan controller's sel.
// Combinational, zero latency; no backpressure.
module mux4 (
   input  logic [3:0] data_in,
   input  logic [1:0] sel,
   output logic       y
);

   assign y = data_in[sel];

endmodule

// File: rtl/mux_scan_next_ch.sv
// Finds the next enabled channel above cur (or at cur when incl=1); found=0 if none.
// Combinational, zero latency; no backpressure.
module mux_scan_next_ch
   import mux_scan_pkg::*;
(
   input  logic [SEL_W-1:0]  cur,
   input  logic [NUM_CH-1:0] mask,
   input  logic              incl,
   output logic [SEL_W-1:0]  nxt,
   output logic              found
);

   // Walk downwards so the lowest qualifying channel is the one left standing.
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
            nxt   = i[SEL_W-1:0];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled mux channels, dwelling DWELL cycles each, and publishes a snapshot on done.
// Pass takes N*DWELL cycles; start is ignored while busy. MUX_SCAN_AUTO_EN adds cont for back-to-back passes.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] mask,
   input  logic              mux_out,
`ifdef MUX_SCAN_AUTO_EN
   input  logic              cont,
`endif
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] sample
);

   localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] shadow_q, shadow_d;
   logic [NUM_CH-1:0] sample_q, sample_d;

   logic [NUM_CH-1:0] first_mask;
   logic [SEL_W-1:0]  first_ch, adv_ch;
   logic              first_found, adv_found;

   // In IDLE the live mask is the one about to be latched; elsewhere only the latched copy counts.
   assign first_mask = (state_q == IDLE) ? mask : mask_q;

   mux_scan_next_ch u_first (
      .cur   ('0),
      .mask  (first_mask),
      .incl  (1'b1),
      .nxt   (first_ch),
      .found (first_found)
   );

   mux_scan_next_ch u_adv (
      .cur   (sel_q),
      .mask  (mask_q),
      .incl  (1'b0),
      .nxt   (adv_ch),
      .found (adv_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         sample_q <= sample_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      sample_d = sample_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               mask_d   = mask;
               shadow_d = '0;
               cnt_d    = '0;
               if (first_found) begin
                  state_d = SCAN;
                  sel_d   = first_ch;
               end else begin
                  state_d  = DONE;
                  sample_d = '0;
               end
            end
         end

         SCAN: begin
            if (cnt_q == DWELL_M1) begin
               shadow_d[sel_q] = mux_out;
               cnt_d           = '0;
               if (adv_found) begin
                  sel_d = adv_ch;
               end else begin
                  // Publish including the bit captured on this same edge.
                  state_d  = DONE;
                  sample_d = shadow_d;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
`ifdef MUX_SCAN_AUTO_EN
            if (cont && first_found) begin
               state_d  = SCAN;
               sel_d    = first_ch;
               cnt_d    = '0;
               shadow_d = '0;
            end
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   assign sel    = sel_q;
   assign busy   = (state_q == SCAN);
   assign done   = (state_q == DONE);
   assign sample = sample_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4, clock cycles spent on each selected channel before sampling; legal range 1..255.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port start  input  1  single-cycle request to begin a scan pass.
REQ-005 Port mask  input  4  channel enable mask; bit i enables channel i.
REQ-006 Port mux_out  input  1  selected bit returned by the downstream 4:1 mux.
REQ-007 Port sel  output  2  channel select driven to the downstream mux.
REQ-008 Port busy  output  1  high while a scan pass is in progress.
REQ-009 Port done  output  1  one-cycle pulse marking completion of a pass.
REQ-010 Port sample  output  4  captured channel bits from the last completed pass; bit i = channel i.

Function
REQ-011 FSM states SHALL be IDLE, SCAN and DONE, with busy = (state == SCAN).
REQ-012 IDLE: on the edge sampling start=1, mask SHALL be latched and the internal shadow register cleared to 0.
  - Latched mask nonzero: next state SCAN, sel = lowest enabled channel, dwell count = 0.
  - Latched mask zero: next state DONE.
REQ-013 SCAN: dwell count SHALL increment each cycle; on the edge where count == DWELL-1, mux_out SHALL be written into shadow[sel].
  - Same edge, a higher enabled channel exists: sel advances to it and count resets.
  - Same edge, no higher enabled channel exists: next state DONE.
REQ-014 DONE SHALL last exactly one cycle with done=1; entering DONE SHALL copy shadow to sample. Next state is IDLE.
REQ-015 With N enabled channels, done SHALL be high in the cycle following the N*DWELL-th edge after the start edge; mask=0 gives done one edge after start.
REQ-016 sample SHALL change only on entry to DONE; it is stable during SCAN and IDLE, and disabled-channel bits read 0.
REQ-017 start while in SCAN or DONE SHALL be ignored; it is not queued.
REQ-018 Changes on mask after the start edge SHALL have no effect on the current pass.
REQ-019 sel SHALL hold its last value in IDLE and DONE.

Reset
REQ-020 rst=1 SHALL force on the next edge: state=IDLE, sel=0, busy=0, done=0, sample=0, shadow=0, dwell count=0, latched mask=0.
REQ-021 rst SHALL take priority over start and over any in-progress scan; an aborted pass SHALL produce no done pulse and no sample update.

Configuration
REQ-022 Macro MUX_SCAN_AUTO_EN defined:
  - adds input port cont (1 bit).
  - In DONE with cont=1 and latched mask nonzero, the next state SHALL be SCAN at the lowest enabled channel, with the shadow cleared.
  - The pass period SHALL then be N*DWELL+1 cycles.
REQ-023 Macro MUX_SCAN_AUTO_EN undefined: port cont SHALL be absent and behaviour is single-shot only, per REQ-014.

Structure
REQ-024 Shared package mux_scan_pkg SHALL hold the state enum (IDLE, SCAN, DONE), NUM_CH=4 and SEL_W=2.
REQ-025 Sub-module mux_scan_next_ch SHALL be a combinational block taking current index and mask, returning the next-higher enabled channel and a found flag. It is used for both the first-channel and the advance decisions.

Verification
REQ-026 Bench SHALL instantiate the existing 4:1 mux downstream of this block (sel->sel, mux out->mux_out) and cover the following scenarios.
REQ-027 DWELL=4, mask=1111, data_in=1010, start pulse -> sel 0,1,2,3 for 4 cycles each; done 16 edges after start; sample=1010; busy high for 16 cycles.
REQ-028 DWELL=4, mask=0101, data_in=1111 -> sel visits 0 then 2 only; done 8 edges after start; sample=0101.
REQ-029 mask=0000, start -> busy never high; done one edge after start; sample=0000.
REQ-030 start re-pulsed at cycle 5 of a 16-cycle scan -> ignored, single done; a new start after done runs a full second pass.
REQ-031 rst at cycle 6 of a scan with sample=1010 from a prior pass -> next edge sel=0, busy=0, sample=0000; no done pulse.
REQ-032 MUX_SCAN_AUTO_EN, cont=1, DWELL=4, mask=1000, data_in[3] toggled between passes -> done every 5 cycles; sample[3] tracks data_in[3], other bits 0.
